// File: rtl/boot_sequencer_ulx3s_pkg.sv
// Shared constants for the ULX3S boot sequencer: FSM state codes, default
// timing values and the registered output bundle.
package boot_seq_pkg;

  localparam logic [2:0] ST_LOCK_WAIT = 3'd0;
  localparam logic [2:0] ST_DETACH    = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_BOOT_WAIT = 3'd3;
  localparam logic [2:0] ST_RECONFIG  = 3'd4;

  localparam int DEF_DEBOUNCE_CYCLES   = 65535;
  localparam int DEF_DETACH_CYCLES     = 65535;
  localparam int DEF_BOOT_DELAY_CYCLES = 48000;  // 1 ms at 48 MHz
  localparam int DEF_PROGRAMN_CYCLES   = 16;
  localparam int DEF_CNT_W             = 16;

  typedef struct packed {
    logic bl_reset;
    logic usb_detach;
    logic programn;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RESET = '{bl_reset: 1'b1, usb_detach: 1'b1, programn: 1'b1};

  // The bootloader core runs (and USB stays attached) only in these states.
  function automatic logic core_running(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_BOOT_WAIT);
  endfunction

endpackage

// File: rtl/boot_sequencer_ulx3s_if.sv
// Signals exchanged between the boot sequencer (master) and the bootloader
// core / board pins (slave).
interface boot_sequencer_ulx3s_if;
  logic       boot_req;
  logic       bl_reset;
  logic       usb_detach;
  logic       programn;
  logic [2:0] state;

  modport master (input boot_req, output bl_reset, usb_detach, programn, state);
  modport slave  (output boot_req, input bl_reset, usb_detach, programn, state);
endinterface

// File: rtl/boot_sequencer_ulx3s_btn_debounce.sv
// User button conditioning: 2-flop synchronizer, stable-count debouncer and
// a registered rising-edge pulse on the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int CNT_W           = 16
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_q <= level_d;
      press_q <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/boot_sequencer_ulx3s.sv
// Reset/boot sequencer: holds the bootloader core in reset with USB detached
// until PLL lock, and on boot request detaches USB and pulses PROGRAMN.
module boot_sequencer_ulx3s
  import boot_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int DETACH_CYCLES     = DEF_DETACH_CYCLES,
  parameter int BOOT_DELAY_CYCLES = DEF_BOOT_DELAY_CYCLES,
  parameter int PROGRAMN_CYCLES   = DEF_PROGRAMN_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic                   clk_48mhz,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   btn_reset,
  boot_sequencer_ulx3s_if.master core
);

  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST   = CNT_W'(BOOT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PROG_LEN    = CNT_W'(PROGRAMN_CYCLES);

  logic             lock_meta_q, lock_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart;
  seq_out_t         out_q, out_d;
  logic             btn_level, btn_press, press_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .btn      (btn_reset),
    .level    (btn_level),
    .press    (btn_press)
  );

  // A press is honoured only while the debounced level still reads held.
  assign press_evt = btn_press & btn_level;

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_LOCK_WAIT: if (lock_s_q) state_d = ST_DETACH;
      ST_DETACH: begin
        if (!lock_s_q)             state_d = ST_LOCK_WAIT;
        else if (press_evt)        restart = 1'b1;
        else if (cnt_q == DETACH_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q)             state_d = ST_LOCK_WAIT;
        else if (press_evt)        state_d = ST_DETACH;
        else if (core.boot_req)    state_d = ST_BOOT_WAIT;
      end
      ST_BOOT_WAIT: begin
        if (!lock_s_q)             state_d = ST_LOCK_WAIT;
        else if (cnt_q == BOOT_LAST) state_d = ST_BOOT_WAIT + 3'd1;
      end
      ST_RECONFIG: state_d = ST_RECONFIG;
      default:     state_d = ST_LOCK_WAIT;
    endcase

    // Shared counter: zero on state entry, saturates instead of wrapping.
    if (restart || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != '1)                cnt_d = cnt_q + 1'b1;
    else                                 cnt_d = cnt_q;

    out_d.bl_reset   = ~core_running(state_d);
    out_d.usb_detach = ~core_running(state_d);
    out_d.programn   = ~((state_d == ST_RECONFIG) && (cnt_d < PROG_LEN));
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_LOCK_WAIT;
      cnt_q       <= '0;
      out_q       <= SEQ_OUT_RESET;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
    end
  end

  assign core.bl_reset   = out_q.bl_reset;
  assign core.usb_detach = out_q.usb_detach;
  assign core.programn   = out_q.programn;
  assign core.state      = state_q;

endmodule
